// File: rtl/flash_audio_sequencer_if.sv
// Avalon-MM read-master bundle between the audio sequencer and the flash controller.
interface flash_audio_sequencer_if #(
    parameter int ADDR_W = 23
);
    logic              flash_read;
    logic [ADDR_W-1:0] flash_addr;
    logic              flash_waitrequest;
    logic [31:0]       flash_readdata;
    logic              flash_readdatavalid;

    modport master (
        output flash_read,
        output flash_addr,
        input  flash_waitrequest,
        input  flash_readdata,
        input  flash_readdatavalid
    );

    modport slave (
        input  flash_read,
        input  flash_addr,
        output flash_waitrequest,
        output flash_readdata,
        output flash_readdatavalid
    );
endinterface

// File: rtl/flash_audio_sequencer.sv
// Fetches 32-bit song words from flash and plays them as two 8-bit samples on sample_tick.
// Define AUDIO_LOOP_EN to wrap at the song boundary instead of stopping there.
module flash_audio_sequencer #(
    parameter int                ADDR_W     = 23,
    parameter logic [ADDR_W-1:0] START_ADDR = 23'h000000,
    parameter logic [ADDR_W-1:0] END_ADDR   = 23'h07FFFF
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic                            direction,
    input  logic                            restart,
    input  logic                            sample_tick,
    flash_audio_sequencer_if.master         bus,
    output logic [7:0]                      audio_sample,
    output logic                            sample_valid,
    output logic                            restart_done,
    output logic                            end_flag
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_REQ       = 3'd1,
        ST_WAIT_DATA = 3'd2,
        ST_PLAY_A    = 3'd3,
        ST_PLAY_B    = 3'd4,
        ST_NEXT      = 3'd5,
        ST_RESTART   = 3'd6
    } state_t;

`ifdef AUDIO_LOOP_EN
    localparam logic LOOP_EN = 1'b1;
`else
    localparam logic LOOP_EN = 1'b0;
`endif

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_r;
    state_t            state_next_s;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] addr_next_s;
    logic              flash_read_r;
    logic [31:0]       word_r;
    logic              order_r;
    logic              pending_r;
    logic              at_end_r;
    logic              end_dir_r;
    logic [7:0]        audio_sample_r;
    logic              sample_valid_r;
    logic              restart_done_r;
    logic              end_flag_r;
    logic              boundary_s;
    logic              resume_ok_s;
    logic              unused_bits_s;

    // The sample is the MSB of a 16-bit half; the low byte of each half is never played.
    function automatic logic [7:0] pick_sample(input logic [31:0] word, input logic upper_half);
        if (upper_half) begin
            return word[31:24];
        end else begin
            return word[15:8];
        end
    endfunction

    assign unused_bits_s = ^{word_r[23:16], word_r[7:0]};

    // Boundary detection and the address the NEXT step will load.
    always_comb begin
        boundary_s  = direction ? (addr_r == END_ADDR) : (addr_r == START_ADDR);
        addr_next_s = addr_r;
        if (boundary_s) begin
            if (LOOP_EN) begin
                addr_next_s = direction ? START_ADDR : END_ADDR;
            end else begin
                addr_next_s = addr_r;
            end
        end else if (direction) begin
            addr_next_s = addr_r + ADDR_ONE;
        end else begin
            addr_next_s = addr_r - ADDR_ONE;
        end
    end

    // After stopping at a boundary, only a reversed direction (or a restart) may resume play.
    assign resume_ok_s = !at_end_r || (direction != end_dir_r);

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (pending_r) begin
                    state_next_s = ST_RESTART;
                end else if (start && resume_ok_s) begin
                    state_next_s = ST_REQ;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (!bus.flash_waitrequest) begin
                    state_next_s = ST_WAIT_DATA;
                end else begin
                    state_next_s = ST_REQ;
                end
            end
            ST_WAIT_DATA: begin
                if (bus.flash_readdatavalid) begin
                    state_next_s = ST_PLAY_A;
                end else begin
                    state_next_s = ST_WAIT_DATA;
                end
            end
            ST_PLAY_A: begin
                if (sample_tick) begin
                    state_next_s = ST_PLAY_B;
                end else begin
                    state_next_s = ST_PLAY_A;
                end
            end
            ST_PLAY_B: begin
                if (sample_tick) begin
                    state_next_s = ST_NEXT;
                end else begin
                    state_next_s = ST_PLAY_B;
                end
            end
            ST_NEXT: begin
                if (boundary_s && !LOOP_EN) begin
                    state_next_s = ST_IDLE;
                end else if (pending_r) begin
                    state_next_s = ST_RESTART;
                end else if (start) begin
                    state_next_s = ST_REQ;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RESTART: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            addr_r         <= START_ADDR;
            flash_read_r   <= 1'b0;
            word_r         <= 32'h0000_0000;
            order_r        <= 1'b0;
            pending_r      <= 1'b0;
            at_end_r       <= 1'b0;
            end_dir_r      <= 1'b0;
            audio_sample_r <= 8'h00;
            sample_valid_r <= 1'b0;
            restart_done_r <= 1'b0;
            end_flag_r     <= 1'b0;
        end else begin
            state_r        <= state_next_s;
            flash_read_r   <= (state_next_s == ST_REQ);
            sample_valid_r <= 1'b0;
            restart_done_r <= 1'b0;
            end_flag_r     <= 1'b0;

            // A request still held during the done pulse is the one just served.
            if (state_r == ST_RESTART) begin
                pending_r <= 1'b0;
            end else if (restart && !restart_done_r) begin
                pending_r <= 1'b1;
            end

            case (state_r)
                ST_IDLE: begin
                    if (state_next_s == ST_REQ) begin
                        at_end_r <= 1'b0;
                    end
                end
                ST_WAIT_DATA: begin
                    if (bus.flash_readdatavalid) begin
                        word_r  <= bus.flash_readdata;
                        order_r <= direction;
                    end
                end
                ST_PLAY_A: begin
                    if (sample_tick) begin
                        audio_sample_r <= pick_sample(word_r, !order_r);
                        sample_valid_r <= 1'b1;
                    end
                end
                ST_PLAY_B: begin
                    if (sample_tick) begin
                        audio_sample_r <= pick_sample(word_r, order_r);
                        sample_valid_r <= 1'b1;
                    end
                end
                ST_NEXT: begin
                    addr_r <= addr_next_s;
                    if (boundary_s) begin
                        end_flag_r <= 1'b1;
                        at_end_r   <= !LOOP_EN;
                        end_dir_r  <= direction;
                    end
                end
                ST_RESTART: begin
                    addr_r         <= direction ? START_ADDR : END_ADDR;
                    restart_done_r <= 1'b1;
                    at_end_r       <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.flash_read  = flash_read_r;
    assign bus.flash_addr  = addr_r;
    assign audio_sample    = audio_sample_r;
    assign sample_valid    = sample_valid_r;
    assign restart_done    = restart_done_r;
    assign end_flag        = end_flag_r;

endmodule

// File: tb/tb_flash_audio_sequencer.sv
// Scoreboard bench for flash_audio_sequencer: a flash model plus queues of expected
// read addresses and samples, popped by a monitor whenever the DUT presents them.
module tb_flash_audio_sequencer;

    localparam int          ADDR_W = 23;
    localparam logic [22:0] S_ADDR = 23'h000000;
    localparam logic [22:0] E_ADDR = 23'h07FFFF;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       direction = 1'b1;
    logic       restart = 1'b0;
    logic       sample_tick = 1'b0;
    logic [7:0] audio_sample;
    logic       sample_valid;
    logic       restart_done;
    logic       end_flag;

    flash_audio_sequencer_if #(.ADDR_W(ADDR_W)) fbus ();

    flash_audio_sequencer #(
        .ADDR_W    (ADDR_W),
        .START_ADDR(S_ADDR),
        .END_ADDR  (E_ADDR)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .direction   (direction),
        .restart     (restart),
        .sample_tick (sample_tick),
        .bus         (fbus),
        .audio_sample(audio_sample),
        .sample_valid(sample_valid),
        .restart_done(restart_done),
        .end_flag    (end_flag)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  exp_smp[$];
    logic [22:0] exp_addr[$];
    int          acc_cnt = 0;
    int          rdv_tot = 0;
    int          end_cnt = 0;
    int          done_cnt = 0;
    int          wr_cnt = 0;
    int          rdv_lat = 2;
    int          rdv_cd = 0;
    logic [31:0] pend_data = 32'h0;
    logic        prev_wait = 1'b0;
    logic [22:0] prev_addr = 23'h0;
    logic        tick_en = 1'b0;
    int          tick_div = 0;

    // Flash contents: two directed words, everything else a simple address pattern.
    function automatic logic [31:0] data_of(input logic [22:0] a);
        if (a == 23'd0) return 32'hA1B2_C3D4;
        else if (a == 23'd5) return 32'h1122_3344;
        else return {~a[7:0], 8'h0F, a[7:0] ^ 8'h5A, 8'hF0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic flag_error(input string name, input logic [31:0] act);
        n_vec++;
        n_err++;
        $display("FAIL %s: got %h, required nothing", name, act);
    endtask

    task automatic expect_word(input logic [22:0] a, input logic [7:0] s1, input logic [7:0] s2);
        exp_addr.push_back(a);
        exp_smp.push_back(s1);
        exp_smp.push_back(s2);
    endtask

    task automatic expect_fill(input logic [22:0] a, input logic fwd);
        logic [31:0] d;
        d = data_of(a);
        if (fwd) expect_word(a, d[15:8], d[31:24]);
        else     expect_word(a, d[31:24], d[15:8]);
    endtask

    task automatic wait_acc(input int target, input int budget);
        int t = 0;
        while (acc_cnt < target && t < budget) begin
            @(negedge clk);
            t++;
        end
        if (acc_cnt < target) flag_error("timeout_read_accept", 32'(acc_cnt));
    endtask

    task automatic wait_rdv(input int target, input int budget);
        int t = 0;
        while (rdv_tot < target && t < budget) begin
            @(negedge clk);
            t++;
        end
        if (rdv_tot < target) flag_error("timeout_readdatavalid", 32'(rdv_tot));
    endtask

    task automatic wait_drained(input int budget);
        int t = 0;
        while ((exp_smp.size() != 0 || exp_addr.size() != 0) && t < budget) begin
            @(negedge clk);
            t++;
        end
        if (exp_smp.size() != 0 || exp_addr.size() != 0)
            flag_error("timeout_drain", 32'(exp_smp.size() + exp_addr.size()));
    endtask

    task automatic do_restart();
        bit seen = 1'b0;
        restart = 1'b1;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (restart_done) begin
                seen = 1'b1;
                break;
            end
        end
        restart = 1'b0;
        if (!seen) flag_error("timeout_restart_done", 32'(done_cnt));
    endtask

    // Sample-rate strobe: one clock in four.
    always @(negedge clk) begin
        if (tick_en) begin
            tick_div    = (tick_div == 3) ? 0 : tick_div + 1;
            sample_tick = (tick_div == 0);
        end else begin
            sample_tick = 1'b0;
        end
    end

    // Flash slave model and output monitor.
    always @(negedge clk) begin
        fbus.flash_readdatavalid = 1'b0;
        if (rdv_cd != 0) begin
            rdv_cd--;
            if (rdv_cd == 0) begin
                fbus.flash_readdatavalid = 1'b1;
                fbus.flash_readdata      = pend_data;
                rdv_tot++;
            end
        end
        if (fbus.flash_read) begin
            if (prev_wait) check("addr_stable_in_wait", 32'(fbus.flash_addr), 32'(prev_addr));
            if (wr_cnt != 0) begin
                fbus.flash_waitrequest = 1'b1;
                wr_cnt--;
                prev_wait = 1'b1;
                prev_addr = fbus.flash_addr;
            end else begin
                fbus.flash_waitrequest = 1'b0;
                prev_wait = 1'b0;
                acc_cnt++;
                if (exp_addr.size() == 0) flag_error("unexpected_read", 32'(fbus.flash_addr));
                else check("read_addr", 32'(fbus.flash_addr), 32'(exp_addr.pop_front()));
                pend_data = data_of(fbus.flash_addr);
                rdv_cd    = rdv_lat;
            end
        end else begin
            if (prev_wait) flag_error("read_dropped_in_wait", 32'(prev_addr));
            prev_wait = 1'b0;
            fbus.flash_waitrequest = 1'b0;
        end
        if (sample_valid) begin
            if (exp_smp.size() == 0) flag_error("unexpected_sample", 32'(audio_sample));
            else check("audio_sample", 32'(audio_sample), 32'(exp_smp.pop_front()));
        end
        if (end_flag) end_cnt++;
        if (restart_done) done_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, required finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        fbus.flash_waitrequest   = 1'b0;
        fbus.flash_readdatavalid = 1'b0;
        fbus.flash_readdata      = 32'h0;
        repeat (3) @(negedge clk);
        check("reset_flash_read", 32'(fbus.flash_read), 32'h0);
        check("reset_flash_addr", 32'(fbus.flash_addr), 32'(S_ADDR));
        check("reset_audio_sample", 32'(audio_sample), 32'h0);
        check("reset_sample_valid", 32'(sample_valid), 32'h0);
        check("reset_restart_done", 32'(restart_done), 32'h0);
        check("reset_end_flag", 32'(end_flag), 32'h0);
        rst_n   = 1'b1;
        tick_en = 1'b1;
        @(negedge clk);

        // Forward from 0, reverse at 5, waitrequest stall on the read of 4, pause after it.
        expect_word(23'd0, 8'hC3, 8'hA1);
        for (int a = 1; a <= 4; a++) expect_fill(23'(a), 1'b1);
        expect_word(23'd5, 8'h11, 8'h33);
        expect_fill(23'd4, 1'b0);
        direction = 1'b1;
        start     = 1'b1;
        wait_acc(6, 2000);
        direction = 1'b0;
        wr_cnt    = 3;
        wait_acc(7, 2000);
        wait_rdv(7, 200);
        start = 1'b0;
        wait_drained(2000);
        repeat (40) @(negedge clk);
        check("pause_no_read_count", 32'(acc_cnt), 32'd7);
        check("pause_flash_read", 32'(fbus.flash_read), 32'h0);

        // Resume from pause: next read continues backward at 3.
        expect_fill(23'd3, 1'b0);
        start = 1'b1;
        wait_acc(8, 2000);
        wait_rdv(8, 200);
        start = 1'b0;
        wait_drained(2000);
        repeat (10) @(negedge clk);
        check("addr_after_pause", 32'(fbus.flash_addr), 32'd2);

        // Restart forward, run up to 0x100, then restart mid-word.
        direction = 1'b1;
        do_restart();
        repeat (2) @(negedge clk);
        check("restart_done_count_1", 32'(done_cnt), 32'd1);
        check("addr_after_restart", 32'(fbus.flash_addr), 32'(S_ADDR));
        for (int a = 0; a <= 256; a++) expect_fill(23'(a), 1'b1);
        n = acc_cnt;
        start = 1'b1;
        wait_acc(n + 257, 10000);
        wait_rdv(n + 257, 200);
        expect_fill(23'd0, 1'b1);
        do_restart();
        wait_acc(n + 258, 2000);
        wait_rdv(n + 258, 200);
        start = 1'b0;
        wait_drained(2000);
        repeat (10) @(negedge clk);
        check("restart_done_count_2", 32'(done_cnt), 32'd2);
        check("addr_after_restart_play", 32'(fbus.flash_addr), 32'd1);

        // Song boundary: restart backward lands on the last word, then play it forward.
        direction = 1'b0;
        do_restart();
        repeat (2) @(negedge clk);
        check("restart_done_count_3", 32'(done_cnt), 32'd3);
        check("addr_restart_backward", 32'(fbus.flash_addr), 32'(E_ADDR));
        direction = 1'b1;
        expect_fill(E_ADDR, 1'b1);
        n = acc_cnt;
`ifdef AUDIO_LOOP_EN
        expect_fill(S_ADDR, 1'b1);
        start = 1'b1;
        wait_acc(n + 2, 2000);
        wait_rdv(n + 2, 200);
        start = 1'b0;
        wait_drained(2000);
        repeat (10) @(negedge clk);
        check("end_flag_count", 32'(end_cnt), 32'd1);
        check("addr_after_wrap", 32'(fbus.flash_addr), 32'd1);
`else
        start = 1'b1;
        wait_acc(n + 1, 2000);
        wait_drained(2000);
        repeat (40) @(negedge clk);
        check("end_flag_count", 32'(end_cnt), 32'd1);
        check("no_read_after_end", 32'(acc_cnt), 32'(n + 1));
        check("end_flash_read_low", 32'(fbus.flash_read), 32'h0);
        check("addr_held_at_end", 32'(fbus.flash_addr), 32'(E_ADDR));
        start = 1'b0;
`endif

        // Reset while a read is outstanding; the late readdatavalid must be ignored.
        direction = 1'b1;
        do_restart();
        repeat (2) @(negedge clk);
        check("addr_before_abort", 32'(fbus.flash_addr), 32'(S_ADDR));
        exp_addr.push_back(S_ADDR);
        rdv_lat = 5;
        n = acc_cnt;
        start = 1'b1;
        wait_acc(n + 1, 2000);
        rst_n = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("late_rdv_delivered", 32'(rdv_tot), 32'(acc_cnt));
        check("abort_audio_sample", 32'(audio_sample), 32'h0);
        check("abort_flash_read", 32'(fbus.flash_read), 32'h0);
        check("abort_flash_addr", 32'(fbus.flash_addr), 32'(S_ADDR));
        check("queues_empty", 32'(exp_smp.size() + exp_addr.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
